// File: rtl/stopwatch_time_counter.sv
// ============================================================================
//  Module   : stopwatch_time_counter
//  Brief    : Cascaded centisecond/second/minute/hour run-time counter with
//             optional lap hold (enable with `define STOPWATCH_LAP_EN).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_time_counter #(
   parameter int MSEC_MAX = 100,
   parameter int SEC_MAX  = 60,
   parameter int MIN_MAX  = 60,
   parameter int HOUR_MAX = 24
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        i_tick,
   input  logic                        clear,
   input  logic                        lap,
   output logic [$clog2(MSEC_MAX)-1:0] o_msec,
   output logic [$clog2(SEC_MAX)-1:0]  o_sec,
   output logic [$clog2(MIN_MAX)-1:0]  o_min,
   output logic [$clog2(HOUR_MAX)-1:0] o_hour,
   output logic                        o_rollover,
   output logic                        o_lap_active
);

   localparam int c_MSEC_W = $clog2(MSEC_MAX);
   localparam int c_SEC_W  = $clog2(SEC_MAX);
   localparam int c_MIN_W  = $clog2(MIN_MAX);
   localparam int c_HOUR_W = $clog2(HOUR_MAX);

   localparam logic [c_MSEC_W-1:0] c_MSEC_LAST = c_MSEC_W'(MSEC_MAX - 1);
   localparam logic [c_SEC_W-1:0]  c_SEC_LAST  = c_SEC_W'(SEC_MAX - 1);
   localparam logic [c_MIN_W-1:0]  c_MIN_LAST  = c_MIN_W'(MIN_MAX - 1);
   localparam logic [c_HOUR_W-1:0] c_HOUR_LAST = c_HOUR_W'(HOUR_MAX - 1);

   localparam logic [c_MSEC_W-1:0] c_MSEC_ONE = c_MSEC_W'(1);
   localparam logic [c_SEC_W-1:0]  c_SEC_ONE  = c_SEC_W'(1);
   localparam logic [c_MIN_W-1:0]  c_MIN_ONE  = c_MIN_W'(1);
   localparam logic [c_HOUR_W-1:0] c_HOUR_ONE = c_HOUR_W'(1);

   logic [c_MSEC_W-1:0] msec_q, msec_d;
   logic [c_SEC_W-1:0]  sec_q,  sec_d;
   logic [c_MIN_W-1:0]  min_q,  min_d;
   logic [c_HOUR_W-1:0] hour_q, hour_d;
   logic                rollover_q, rollover_d;

   logic w_msec_wrap, w_sec_wrap, w_min_wrap, w_hour_wrap;

   assign w_msec_wrap = (msec_q == c_MSEC_LAST);
   assign w_sec_wrap  = (sec_q  == c_SEC_LAST);
   assign w_min_wrap  = (min_q  == c_MIN_LAST);
   assign w_hour_wrap = (hour_q == c_HOUR_LAST);

   // Whole carry chain resolves in one cycle so no field ever shows its modulus.
   always_comb begin
      msec_d     = msec_q;
      sec_d      = sec_q;
      min_d      = min_q;
      hour_d     = hour_q;
      rollover_d = 1'b0;
      if (clear) begin
         msec_d = '0;
         sec_d  = '0;
         min_d  = '0;
         hour_d = '0;
      end else if (i_tick) begin
         rollover_d = w_msec_wrap & w_sec_wrap & w_min_wrap & w_hour_wrap;
         if (!w_msec_wrap) begin
            msec_d = msec_q + c_MSEC_ONE;
         end else begin
            msec_d = '0;
            if (!w_sec_wrap) begin
               sec_d = sec_q + c_SEC_ONE;
            end else begin
               sec_d = '0;
               if (!w_min_wrap) begin
                  min_d = min_q + c_MIN_ONE;
               end else begin
                  min_d  = '0;
                  hour_d = w_hour_wrap ? '0 : hour_q + c_HOUR_ONE;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         msec_q     <= '0;
         sec_q      <= '0;
         min_q      <= '0;
         hour_q     <= '0;
         rollover_q <= 1'b0;
      end else begin
         msec_q     <= msec_d;
         sec_q      <= sec_d;
         min_q      <= min_d;
         hour_q     <= hour_d;
         rollover_q <= rollover_d;
      end
   end

   assign o_rollover = rollover_q;

`ifdef STOPWATCH_LAP_EN
   localparam logic [0:0] c_ST_LIVE = 1'b0;
   localparam logic [0:0] c_ST_HOLD = 1'b1;

   logic [0:0]          state_q, state_d;
   logic [c_MSEC_W-1:0] hold_msec_q, hold_msec_d;
   logic [c_SEC_W-1:0]  hold_sec_q,  hold_sec_d;
   logic [c_MIN_W-1:0]  hold_min_q,  hold_min_d;
   logic [c_HOUR_W-1:0] hold_hour_q, hold_hour_d;

   // Capture uses the pre-edge live values, i.e. what is on the display now.
   always_comb begin
      state_d     = state_q;
      hold_msec_d = hold_msec_q;
      hold_sec_d  = hold_sec_q;
      hold_min_d  = hold_min_q;
      hold_hour_d = hold_hour_q;
      if (clear) begin
         state_d = c_ST_LIVE;
      end else if (lap) begin
         if (state_q == c_ST_LIVE) begin
            state_d     = c_ST_HOLD;
            hold_msec_d = msec_q;
            hold_sec_d  = sec_q;
            hold_min_d  = min_q;
            hold_hour_d = hour_q;
         end else begin
            state_d = c_ST_LIVE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= c_ST_LIVE;
         hold_msec_q <= '0;
         hold_sec_q  <= '0;
         hold_min_q  <= '0;
         hold_hour_q <= '0;
      end else begin
         state_q     <= state_d;
         hold_msec_q <= hold_msec_d;
         hold_sec_q  <= hold_sec_d;
         hold_min_q  <= hold_min_d;
         hold_hour_q <= hold_hour_d;
      end
   end

   assign o_lap_active = (state_q == c_ST_HOLD);
   assign o_msec       = o_lap_active ? hold_msec_q : msec_q;
   assign o_sec        = o_lap_active ? hold_sec_q  : sec_q;
   assign o_min        = o_lap_active ? hold_min_q  : min_q;
   assign o_hour       = o_lap_active ? hold_hour_q : hour_q;
`else
   // Lap input is inert in this build; it is only folded away here.
   assign o_lap_active = lap & 1'b0;
   assign o_msec       = msec_q;
   assign o_sec        = sec_q;
   assign o_min        = min_q;
   assign o_hour       = hour_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_time_counter.sv
// ============================================================================
//  Module   : tb_stopwatch_time_counter
//  Brief    : Directed self-checking bench; a full-size counter plus a
//             small-modulus copy used to reach the hour and full wraps quickly.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_time_counter;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic tick_a = 1'b0;
   logic tick_b = 1'b0;
   logic clear = 1'b0;
   logic lap = 1'b0;

   logic [6:0] a_msec;
   logic [5:0] a_sec;
   logic [5:0] a_min;
   logic [4:0] a_hour;
   logic       a_roll, a_lap;

   logic [1:0] b_msec;
   logic [1:0] b_sec;
   logic [1:0] b_min;
   logic [0:0] b_hour;
   logic       b_roll, b_lap;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   stopwatch_time_counter u_dut_a (
      .clk          (clk),
      .reset        (reset),
      .i_tick       (tick_a),
      .clear        (clear),
      .lap          (lap),
      .o_msec       (a_msec),
      .o_sec        (a_sec),
      .o_min        (a_min),
      .o_hour       (a_hour),
      .o_rollover   (a_roll),
      .o_lap_active (a_lap)
   );

   stopwatch_time_counter #(
      .MSEC_MAX (4),
      .SEC_MAX  (3),
      .MIN_MAX  (3),
      .HOUR_MAX (2)
   ) u_dut_b (
      .clk          (clk),
      .reset        (reset),
      .i_tick       (tick_b),
      .clear        (clear),
      .lap          (lap),
      .o_msec       (b_msec),
      .o_sec        (b_sec),
      .o_min        (b_min),
      .o_hour       (b_hour),
      .o_rollover   (b_roll),
      .o_lap_active (b_lap)
   );

   function automatic logic [31:0] tm(input int h, input int m, input int s, input int c);
      logic [4:0] hh = h[4:0];
      logic [5:0] mm = m[5:0];
      logic [5:0] ss = s[5:0];
      logic [6:0] cc = c[6:0];
      return {8'd0, hh, mm, ss, cc};
   endfunction

   function automatic logic [31:0] ts(input int h, input int m, input int s, input int c);
      logic [0:0] hh = h[0:0];
      logic [1:0] mm = m[1:0];
      logic [1:0] ss = s[1:0];
      logic [1:0] cc = c[1:0];
      return {25'd0, hh, mm, ss, cc};
   endfunction

   function automatic logic [31:0] disp_a();
      return {8'd0, a_hour, a_min, a_sec, a_msec};
   endfunction

   function automatic logic [31:0] disp_b();
      return {25'd0, b_hour, b_min, b_sec, b_msec};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      // reset asserted from time 0
      #3;
      chk("reset_a_time", disp_a(), tm(0, 0, 0, 0));
      chk("reset_b_time", disp_b(), ts(0, 0, 0, 0));
      chk("reset_flags", {28'd0, a_roll, a_lap, b_roll, b_lap}, 32'd0);
      cyc(2);
      reset = 1'b1;
      cyc(1);

      // small copy: hour carry and full wrap
      tick_b = 1'b1; cyc(35); tick_b = 1'b0;
      chk("b_pre_hour", disp_b(), ts(0, 2, 2, 3));
      tick_b = 1'b1; cyc(1); tick_b = 1'b0;
      chk("b_hour_carry", disp_b(), ts(1, 0, 0, 0));
      chk("b_no_roll", {31'd0, b_roll}, 32'd0);
      tick_b = 1'b1; cyc(35); tick_b = 1'b0;
      chk("b_at_max", disp_b(), ts(1, 2, 2, 3));
      tick_b = 1'b1; cyc(1); tick_b = 1'b0;
      chk("b_wrap", disp_b(), ts(0, 0, 0, 0));
      chk("b_roll_pulse", {31'd0, b_roll}, 32'd1);
      cyc(1);
      chk("b_roll_clear", {31'd0, b_roll}, 32'd0);
      chk("b_stays_zero", disp_b(), ts(0, 0, 0, 0));

      // full-size counter
      tick_a = 1'b1; cyc(99); tick_a = 1'b0;
      chk("a_99", disp_a(), tm(0, 0, 0, 99));
      tick_a = 1'b1; cyc(1); tick_a = 1'b0;
      chk("a_1s", disp_a(), tm(0, 0, 1, 0));
      chk("a_no_roll", {31'd0, a_roll}, 32'd0);
      tick_a = 1'b1; cyc(5899); tick_a = 1'b0;
      chk("a_59_99", disp_a(), tm(0, 0, 59, 99));
      tick_a = 1'b1; cyc(1); tick_a = 1'b0;
      chk("a_1min", disp_a(), tm(0, 1, 0, 0));

      // clear alone, then clear against a simultaneous tick
      clear = 1'b1; cyc(1); clear = 1'b0;
      chk("a_clear", disp_a(), tm(0, 0, 0, 0));
      tick_a = 1'b1; cyc(542); tick_a = 1'b0;
      chk("a_5_42", disp_a(), tm(0, 0, 5, 42));
      clear = 1'b1; tick_a = 1'b1; cyc(1); clear = 1'b0; tick_a = 1'b0;
      chk("a_clear_tick", disp_a(), tm(0, 0, 0, 0));
      tick_a = 1'b1; cyc(1); tick_a = 1'b0;
      chk("a_after_clear", disp_a(), tm(0, 0, 0, 1));

      clear = 1'b1; cyc(1); clear = 1'b0;
      tick_a = 1'b1; cyc(310); tick_a = 1'b0;
      chk("a_3_10", disp_a(), tm(0, 0, 3, 10));
      lap = 1'b1; tick_a = 1'b1; cyc(1); lap = 1'b0; tick_a = 1'b0;
`ifdef STOPWATCH_LAP_EN
      chk("lap_frozen", disp_a(), tm(0, 0, 3, 10));
      chk("lap_active", {31'd0, a_lap}, 32'd1);
      tick_a = 1'b1; cyc(50); tick_a = 1'b0;
      chk("lap_still_frozen", disp_a(), tm(0, 0, 3, 10));
      lap = 1'b1; cyc(1); lap = 1'b0;
      chk("lap_release", disp_a(), tm(0, 0, 3, 61));
      chk("lap_inactive", {31'd0, a_lap}, 32'd0);
      lap = 1'b1; cyc(1); lap = 1'b0;
      chk("lap_hold_again", {31'd0, a_lap}, 32'd1);
`else
      chk("lap_ignored", disp_a(), tm(0, 0, 3, 11));
      chk("lap_inactive", {31'd0, a_lap}, 32'd0);
`endif

      // asynchronous reset mid-count (in HOLD when the lap feature is built)
      tick_a = 1'b1; cyc(7);
      #2;
      reset = 1'b0;
      #1;
      chk("async_reset_time", disp_a(), tm(0, 0, 0, 0));
      chk("async_reset_flags", {30'd0, a_roll, a_lap}, 32'd0);
      tick_a = 1'b0;
      cyc(1);
      reset = 1'b1;
      tick_a = 1'b1; cyc(3); tick_a = 1'b0;
      chk("resume_after_reset", disp_a(), tm(0, 0, 0, 3));
      chk("resume_lap_flag", {31'd0, a_lap}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/stopwatch_time_counter.md
# stopwatch_time_counter

Cascaded time-of-run counter for the stopwatch. Consumes the single-cycle 100 Hz tick produced by the stopwatch clock divider and advances centisecond, second, minute and hour fields with carry propagation. Outputs drive the FND/display formatting stage directly. An optional lap-hold feature freezes the displayed value while counting continues underneath.

## Interface
- `MSEC_MAX`, 100, centisecond field modulus (field counts 0..MSEC_MAX-1)
- `SEC_MAX`, 60, second field modulus
- `MIN_MAX`, 60, minute field modulus
- `HOUR_MAX`, 24, hour field modulus
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `i_tick`  in  1  increment strobe from the divider; one increment per cycle it is high
- `clear`  in  1  synchronous clear of all fields
- `lap`  in  1  lap toggle pulse; ignored when `LAP_EN` is undefined
- `o_msec`  out  $clog2(MSEC_MAX)  displayed centiseconds
- `o_sec`  out  $clog2(SEC_MAX)  displayed seconds
- `o_min`  out  $clog2(MIN_MAX)  displayed minutes
- `o_hour`  out  $clog2(HOUR_MAX)  displayed hours
- `o_rollover`  out  1  one-cycle pulse when the full count wraps to zero
- `o_lap_active`  out  1  high while display is frozen (constant 0 without `LAP_EN`)

Clock is `clk`; reset is `reset`, asynchronous and active-low.

## Operation
- Four live registers: msec, sec, min, hour. On `i_tick`: msec+1; at MSEC_MAX-1 it wraps to 0 and carries into sec; same chain sec→min→hour.
- Hour wrap: at HOUR_MAX-1:MIN_MAX-1:SEC_MAX-1:MSEC_MAX-1 a tick returns all fields to 0 and asserts `o_rollover` for exactly one cycle (registered).
- Carries resolve in the same cycle; no field ever shows a value ≥ its modulus.
- `clear` high: all live fields ← 0, `o_rollover` ← 0, lap state ← LIVE. Clear has priority over `i_tick` and `lap` in the same cycle.
- `i_tick` held high N cycles = N increments; the divider guarantees single-cycle pulses, the block does not edge-detect.
- Lap FSM (with `LAP_EN`): states LIVE, HOLD.
  - LIVE: outputs mirror live registers. `lap` → capture live values (pre-edge, i.e. the values currently displayed) into hold registers, go HOLD.
  - HOLD: outputs show hold registers; live registers keep counting. `lap` → LIVE.
  - `lap` and `i_tick` in same cycle: capture pre-increment value; increment still applies to live registers.
  - `o_lap_active` = (state == HOLD).
- Reset (any time, mid-count or in HOLD): all fields, hold registers, `o_rollover` = 0, state = LIVE, `o_lap_active` = 0.

## Timing
- All outputs registered; `i_tick` sampled at edge N updates outputs visible after edge N.
- `o_rollover` high for the cycle following the wrapping edge only.
- `lap` toggle effect visible on outputs after the sampling edge; one-cycle latency.
- `clear` takes effect at the sampling edge; outputs 0 after it.
- No back-pressure or handshake; tick rate limited only by one per cycle.

## Configuration
- `STOPWATCH_LAP_EN` defined: hold registers and LIVE/HOLD FSM compiled in; `lap` functional.
- Undefined: no hold registers, no FSM; `lap` ignored; outputs always live; `o_lap_active` tied to 0.

## Test plan
- Reset release, 99 ticks → 00:00:00.99; 1 more tick → 00:00:01.00, no rollover.
- Preload via ticks to 00:59:59.99, 1 tick → 01:00:00.00 (three carries in one cycle).
- Count to 23:59:59.99, 1 tick → 00:00:00.00, `o_rollover` high exactly one cycle.
- `clear` and `i_tick` same cycle at 00:00:05.42 → 00:00:00.00; next tick → 00:00:00.01.
- (`STOPWATCH_LAP_EN`) at 00:00:03.10 pulse `lap` with `i_tick` → display frozen at 00:00:03.10, `o_lap_active`=1; 50 more ticks, pulse `lap` → display 00:00:03.61, `o_lap_active`=0.
- Assert `reset` low mid-count in HOLD → all outputs 0, `o_lap_active`=0 immediately (async); counting resumes from 0 after release.
